// File: rtl/noc_local_injector_if.sv
// noc_local_injector_if: descriptor, payload, flit and credit signals of the
// local-port injector. The master modport is the injector side (it sources
// flits towards the router); the slave modport is the core/router side.
interface noc_local_injector_if #(
  parameter int P_DATA_WIDTH   = 32,
  parameter int P_ID_WIDTH     = 4,
  parameter int P_LEN_WIDTH    = 4,
  parameter int P_CREDIT_WIDTH = 3
);
  logic                      desc_valid;
  logic                      desc_ready;
  logic [P_ID_WIDTH-1:0]     desc_dst;
  logic [P_LEN_WIDTH-1:0]    desc_len;
  logic                      pld_valid;
  logic                      pld_ready;
  logic [P_DATA_WIDTH-3:0]   pld_data;
  logic [P_DATA_WIDTH-1:0]   out_data;
  logic                      out_data_valid;
  logic [P_CREDIT_WIDTH-1:0] in_credits;

  modport master (
    input  desc_valid, desc_dst, desc_len,
    output desc_ready,
    input  pld_valid, pld_data,
    output pld_ready,
    output out_data, out_data_valid,
    input  in_credits
  );

  modport slave (
    output desc_valid, desc_dst, desc_len,
    input  desc_ready,
    output pld_valid, pld_data,
    input  pld_ready,
    input  out_data, out_data_valid,
    output in_credits
  );
endinterface

// File: rtl/noc_local_injector.sv
// noc_local_injector: turns a (dst, len) descriptor plus a payload stream into
// head/body/tail flits on a router local input, launching a flit only while
// the router still has free buffer slots after subtracting flits in flight.
// Optional build macro INJ_STATS_EN adds pkt_count / stall_count outputs.
module noc_local_injector #(
  parameter int P_DATA_WIDTH   = 32,
  parameter int P_ID_WIDTH     = 4,
  parameter int P_LEN_WIDTH    = 4,
  parameter int P_CREDIT_WIDTH = 3,
  parameter int P_CREDIT_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [P_ID_WIDTH-1:0] router_id,
  noc_local_injector_if.master  bus,
  output logic                  busy
`ifdef INJ_STATS_EN
  ,
  output logic [15:0]           pkt_count,
  output logic [15:0]           stall_count
`endif
);

  localparam int CNT_W = P_CREDIT_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  state_t                   state_reg, state_next;
  logic [P_ID_WIDTH-1:0]    dst_reg, dst_next;
  logic [P_LEN_WIDTH-1:0]   len_reg, len_next;
  logic [P_LEN_WIDTH-1:0]   remaining_reg, remaining_next;
  logic [P_CREDIT_LAT-1:0]  inflight_reg;
  logic [P_DATA_WIDTH-1:0]  out_data_reg;
  logic                     out_valid_reg;

  logic [CNT_W-1:0]         inflight_cnt;
  logic [CNT_W-1:0]         credits_ext;
  logic [CNT_W-1:0]         avail;
  logic                     can_launch;
  logic                     launch;
  logic                     last_launch;
  logic [P_DATA_WIDTH-1:0]  flit;
  logic                     desc_ready_c;
  logic                     pld_ready_c;

  // Free slots left after discounting flits the router has not yet reported.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < P_CREDIT_LAT; i++) begin
      inflight_cnt = inflight_cnt + {{(CNT_W-1){1'b0}}, inflight_reg[i]};
    end
    credits_ext = {1'b0, bus.in_credits};
    avail       = (credits_ext > inflight_cnt) ? (credits_ext - inflight_cnt) : '0;
    can_launch  = (avail != '0);
  end

  // Next-state, launch decision and flit formatting.
  always_comb begin
    state_next     = state_reg;
    dst_next       = dst_reg;
    len_next       = len_reg;
    remaining_next = remaining_reg;
    desc_ready_c   = 1'b0;
    pld_ready_c    = 1'b0;
    launch         = 1'b0;
    last_launch    = 1'b0;
    flit           = '0;
    case (state_reg)
      ST_IDLE: begin
        desc_ready_c = 1'b1;
        if (bus.desc_valid) begin
          dst_next       = bus.desc_dst;
          len_next       = bus.desc_len;
          remaining_next = bus.desc_len;
          state_next     = ST_HEAD;
        end
      end
      ST_HEAD: begin
        flit[P_ID_WIDTH-1:0]                          = dst_reg;
        flit[2*P_ID_WIDTH-1:P_ID_WIDTH]               = router_id;
        flit[2*P_ID_WIDTH+P_LEN_WIDTH-1:2*P_ID_WIDTH] = len_reg;
        flit[P_DATA_WIDTH-1:P_DATA_WIDTH-2]           = (len_reg == '0) ? 2'b11 : 2'b01;
        if (can_launch) begin
          launch = 1'b1;
          if (len_reg == '0) begin
            last_launch = 1'b1;
            state_next  = ST_IDLE;
          end else begin
            state_next = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        pld_ready_c                         = can_launch;
        flit[P_DATA_WIDTH-3:0]              = bus.pld_data;
        flit[P_DATA_WIDTH-1:P_DATA_WIDTH-2] = (remaining_reg == 1) ? 2'b10 : 2'b00;
        if (bus.pld_valid && can_launch) begin
          launch         = 1'b1;
          // Never decremented from zero: BODY is only entered with len > 0.
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == 1) begin
            last_launch = 1'b1;
            state_next  = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state and packet context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      dst_reg       <= '0;
      len_reg       <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      dst_reg       <= dst_next;
      len_reg       <= len_next;
      remaining_reg <= remaining_next;
    end
  end

  // History of launches still invisible in the router's credit count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= '0;
    end else begin
      for (int i = P_CREDIT_LAT - 1; i > 0; i--) begin
        inflight_reg[i] <= inflight_reg[i-1];
      end
      inflight_reg[0] <= launch;
    end
  end

  // Registered flit output; data holds through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= launch;
      if (launch) begin
        out_data_reg <= flit;
      end
    end
  end

  assign bus.out_data       = out_data_reg;
  assign bus.out_data_valid = out_valid_reg;
  // Gated by rst_n so the core sees no ready while reset is held.
  assign bus.desc_ready     = desc_ready_c & rst_n;
  assign bus.pld_ready      = pld_ready_c;
  assign busy               = (state_reg != ST_IDLE);

`ifdef INJ_STATS_EN
  logic [15:0] pkt_count_reg;
  logic [15:0] stall_count_reg;

  // Packet completions (wrapping) and credit-starved cycles (saturating).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_reg   <= '0;
      stall_count_reg <= '0;
    end else begin
      if (last_launch) begin
        pkt_count_reg <= pkt_count_reg + 16'd1;
      end
      if ((state_reg != ST_IDLE) && !can_launch && (stall_count_reg != 16'hFFFF)) begin
        stall_count_reg <= stall_count_reg + 16'd1;
      end
    end
  end

  assign pkt_count   = pkt_count_reg;
  assign stall_count = stall_count_reg;
`else
  // Completion strobe only feeds the statistics counters.
  logic unused_last;
  assign unused_last = last_launch;
`endif

endmodule

// File: tb/tb_noc_local_injector.sv
// tb_noc_local_injector: scoreboard bench. Expected flits are queued as each
// descriptor/payload word is driven and compared as flits leave the DUT;
// per-flit cycle stamps are used for spacing and credit-budget checks.
module tb_noc_local_injector;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int LW = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] router_id = 4'd3;
  logic          busy;
`ifdef INJ_STATS_EN
  logic [15:0]   pkt_count;
  logic [15:0]   stall_count;
`endif

  always #5 clk = ~clk;

  noc_local_injector_if #(.P_DATA_WIDTH(DW), .P_ID_WIDTH(IW), .P_LEN_WIDTH(LW),
                          .P_CREDIT_WIDTH(CW)) bus ();

  noc_local_injector #(
    .P_DATA_WIDTH(DW), .P_ID_WIDTH(IW), .P_LEN_WIDTH(LW),
    .P_CREDIT_WIDTH(CW), .P_CREDIT_LAT(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .router_id(router_id),
    .bus(bus),
    .busy(busy)
`ifdef INJ_STATS_EN
    ,
    .pkt_count(pkt_count),
    .stall_count(stall_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int busy_cycles = 0;
  int ftime[$];
  logic [DW-1:0] sb[$];
  bit abort = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] head_flit(input logic [3:0] dst, input logic [3:0] src,
                                              input logic [3:0] len);
    logic [DW-1:0] f;
    f = '0;
    f[3:0]   = dst;
    f[7:4]   = src;
    f[11:8]  = len;
    f[31:30] = (len == 4'd0) ? 2'b11 : 2'b01;
    return f;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every emitted flit against the scoreboard head.
  initial begin
    logic [DW-1:0] exp;
    forever begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (rst_n && bus.out_data_valid) begin
        check("sb_occupancy", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check("flit", 64'(bus.out_data), 64'(exp));
          $display("flit @%0d data=%08h expected=%08h", cyc, bus.out_data, exp);
        end
        ftime.push_back(cyc);
      end
    end
  end

  task automatic send_desc(input logic [3:0] dst, input logic [3:0] len);
    int t = 0;
    bus.desc_dst = dst;
    bus.desc_len = len;
    bus.desc_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (abort || bus.desc_ready) break;
      t++;
      if (t > 200) begin
        check("desc_handshake", 64'(bus.desc_ready), 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.desc_valid = 1'b0;
  endtask

  task automatic send_word(input logic [29:0] d, input int gap);
    int t = 0;
    bus.pld_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.pld_data = d;
    bus.pld_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (abort || bus.pld_ready) break;
      t++;
      if (t > 200) begin
        check("pld_handshake", 64'(bus.pld_ready), 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.pld_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [3:0] dst, input logic [3:0] len,
                             input int gap_idx, input int gap_len);
    logic [29:0] w;
    sb.push_back(head_flit(dst, router_id, len));
    send_desc(dst, len);
    for (int i = 0; i < int'(len); i++) begin
      if (abort) return;
      w = 30'($urandom);
      sb.push_back({(i == int'(len) - 1) ? 2'b10 : 2'b00, w});
      send_word(w, (i == gap_idx) ? gap_len : 0);
    end
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int f0;
    int b0;
    int t;
    bus.desc_valid = 1'b0; bus.desc_dst = '0; bus.desc_len = '0;
    bus.pld_valid = 1'b0;  bus.pld_data = '0;
    bus.in_credits = 3'd4;
    #1;
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_valid", 64'(bus.out_data_valid), 64'd0);
    check("rst_desc_ready", 64'(bus.desc_ready), 64'd0);
    check("rst_pld_ready", 64'(bus.pld_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("idle_desc_ready", 64'(bus.desc_ready), 64'd1);
    @(posedge clk); #1;

    // Head-only packet.
    b0 = busy_cycles; f0 = ftime.size();
    send_packet(4'd5, 4'd0, -1, 0);
    wait_done("t1_drain");
    check("t1_busy_cycles", 64'(busy_cycles - b0), 64'd1);
    check("t1_flit_count", 64'(ftime.size() - f0), 64'd1);

    // Three-word packet, ample credits: back-to-back flits.
    f0 = ftime.size();
    send_packet(4'd2, 4'd3, -1, 0);
    wait_done("t2_drain");
    check("t2_flit_count", 64'(ftime.size() - f0), 64'd4);
    if (ftime.size() - f0 == 4)
      for (int i = 1; i < 4; i++) check("t2_spacing", 64'(ftime[f0+i] - ftime[f0+i-1]), 64'd1);

    // One credit, two-cycle credit latency: one flit per three cycles.
    bus.in_credits = 3'd1;
    f0 = ftime.size();
    send_packet(4'd7, 4'd3, -1, 0);
    wait_done("t3_drain");
    check("t3_flit_count", 64'(ftime.size() - f0), 64'd4);
    if (ftime.size() - f0 == 4)
      for (int i = 1; i < 4; i++) check("t3_spacing", 64'(ftime[f0+i] - ftime[f0+i-1]), 64'd3);
    bus.in_credits = 3'd4;

    // Payload stalls for two cycles before the third word.
    f0 = ftime.size();
    send_packet(4'd9, 4'd4, 2, 2);
    wait_done("t4_drain");
    check("t4_flit_count", 64'(ftime.size() - f0), 64'd5);
    if (ftime.size() - f0 == 5) begin
      check("t4_gap", 64'(ftime[f0+3] - ftime[f0+2]), 64'd3);
      check("t4_after_gap", 64'(ftime[f0+4] - ftime[f0+3]), 64'd1);
    end

    // Reset in the middle of a len=5 packet.
    f0 = ftime.size();
    fork
      send_packet(4'd4, 4'd5, -1, 0);
    join_none
    t = 0;
    while (ftime.size() < f0 + 3 && t < 100) begin @(negedge clk); t++; end
    check("t5_progress", 64'(ftime.size() >= f0 + 3), 64'd1);
    @(posedge clk); #1;
    check("t5_valid_before_rst", 64'(bus.out_data_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(bus.out_data_valid), 64'd0);
    check("t5_rst_data", 64'(bus.out_data), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_desc_ready", 64'(bus.desc_ready), 64'd0);
    abort = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    sb.delete();
    bus.desc_valid = 1'b0;
    bus.pld_valid = 1'b0;
    rst_n = 1'b1;
    abort = 1'b0;
    f0 = ftime.size();
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_tail", 64'(ftime.size() - f0), 64'd0);
    f0 = ftime.size();
    send_packet(4'd6, 4'd1, -1, 0);
    wait_done("t5_drain");
    check("t5_flit_count", 64'(ftime.size() - f0), 64'd2);
    if (ftime.size() - f0 == 2)
      check("t5_spacing", 64'(ftime[f0+1] - ftime[f0]), 64'd1);

    // Maximum length packet: remaining must not wrap.
    f0 = ftime.size();
    send_packet(4'd8, 4'd15, -1, 0);
    wait_done("tmax_drain");
    check("tmax_flit_count", 64'(ftime.size() - f0), 64'd16);

`ifdef INJ_STATS_EN
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check("st_rst_pkt", 64'(pkt_count), 64'd0);
    check("st_rst_stall", 64'(stall_count), 64'd0);
    send_packet(4'd1, 4'd2, -1, 0);
    wait_done("st_drain1");
    bus.in_credits = 3'd0;
    fork
      send_packet(4'd2, 4'd1, -1, 0);
    join_none
    t = 0;
    while (!busy && t < 50) begin @(negedge clk); t++; end
    check("st_in_head", 64'(busy), 64'd1);
    repeat (10) @(posedge clk);
    #1 bus.in_credits = 3'd4;
    wait_done("st_drain2");
    send_packet(4'd3, 4'd0, -1, 0);
    wait_done("st_drain3");
    check("st_pkt_count", 64'(pkt_count), 64'd3);
    check("st_stall_count", 64'(stall_count), 64'd10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
